fiat_25519_carry_square_mul_pipe: RTL
=====================================

Name: fiat_25519_carry_square_mul_pipe

Overview:
- Parametrised, pipelined integer multiplier with a valid/ready handshake, for the fiat_25519 carry/square datapath.
- Successor to the single-cycle combinational multiplier primitive: selectable operand/result widths, pipeline depth NUM_STAGE >= 1, unsigned or signed mode, clock enable and output backpressure.
- Sits between limb-fetch logic and the carry-reduction adder tree; feeds one product per cycle when unstalled.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, register stages from din to dout; legal range 1..8.
- din0_WIDTH, 39, width of operand 0.
- din1_WIDTH, 6, width of operand 1.
- dout_WIDTH, 44, result width; product is truncated or extended to this width.
- SIGNED, 0, 0 = both operands unsigned (zero-extend); 1 = both two's-complement (sign-extend).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when 0 no pipeline state changes.
- din_valid  in  1  operand pair valid.
- din_ready  out  1  block accepts operands this cycle.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts result.
- dout  out  dout_WIDTH  product.

Behaviour:
- Arithmetic:
  - P = ext(din0) * ext(din1), computed at full width din0_WIDTH+din1_WIDTH.
  - ext is a zero-extend when SIGNED=0 and a sign-extend when SIGNED=1.
  - dout = P[dout_WIDTH-1:0] when dout_WIDTH <= full width. Otherwise P is zero- or sign-extended per SIGNED.
- Pipeline:
  - NUM_STAGE stages; stage k holds valid bit v[k] and data d[k].
  - Stage 0 captures the operands. The multiply is split across stages as partial products over din1 slices of ceil(din1_WIDTH/NUM_STAGE) bits, accumulated stage by stage. The last stage holds the final product.
- Advance rule (bubble-collapsing), evaluated only when ce=1:
  - adv[N-1] = !v[N-1] | dout_ready.
  - adv[k] = !v[k] | adv[k+1].
  - din_ready = ce & adv[0].
  - On an edge where stage k advances: it loads from stage k-1 (stage 0 loads from the inputs).
  - On that edge, v[k] = v[k-1], or din_valid & din_ready for stage 0.
  - A stage that does not advance holds its value.
- Outputs: dout_valid = v[N-1]; dout = d[N-1] result field.
- Latency: exactly NUM_STAGE cycles from an accepted input to dout_valid, given ce=1 and dout_ready=1 throughout.
- Throughput: one result per cycle.
- Backpressure:
  - With dout_ready=0 and all stages full, din_ready=0, and dout and dout_valid hold stable until accepted.
  - Empty stages keep filling while downstream is stalled.
- ce=0:
  - din_ready=0; the pipeline is frozen.
  - dout and dout_valid hold; a transfer does not occur even if dout_ready=1.
- Simultaneous accept and emit with a full pipe: permitted, with no loss or duplication.
- Reset (asynchronous, including mid-operation):
  - All v[k]=0 and all d[k]=0 immediately, so dout_valid=0 and dout=0.
  - In-flight products are discarded.
  - din_ready becomes ce after reset deasserts.
- Ordering: results emerge in acceptance order; no reordering.

Decomposition:
- Shared package fiat_25519_mul_pkg holds:
  - function calc_slice_width(din1_WIDTH, NUM_STAGE);
  - localparam FULL_WIDTH;
  - stage record typedef {valid, acc[FULL_WIDTH], a[din0_WIDTH], b_rem[din1_WIDTH]}.
- Sub-module fiat_25519_mul_pipe_stage: one partial-product/accumulate register stage, instantiated NUM_STAGE times via generate.
- The top level holds only the ready chain and output truncation.

Test Plan:
- Max unsigned operands: defaults, din0=0x7FFFFFFFFF, din1=0x3F, single accept -> dout_valid exactly 3 cycles later, dout=0xF7FFFFFFFC1 (truncated from 45 bits).
- Signed mode: SIGNED=1, din0 all ones (-1), din1=6'b111111 (-1) -> dout=1. Then din0=-2, din1=3 -> dout=0xFFFFFFFFFFA (-6).
- Streaming: 100 random pairs back-to-back, dout_ready=1 -> 100 results in order, one per cycle, matching the model.
- Backpressure: fill the pipe, hold dout_ready=0 for 10 cycles -> din_ready=0 after 3 accepts plus 1 held output, dout stable. On release -> no loss or duplication.
- ce stall: ce=0 for 5 cycles mid-stream -> no state change, din_ready=0. On resume -> results identical to the ce=1 run, shifted by 5 cycles.
- Reset mid-operation: reset asserted with 2 products in flight -> dout_valid=0 and dout=0 asynchronously. After release, the first new input yields the correct product with no stale outputs.

Source files
------------

// File: rtl/fiat_25519_mul_pkg.sv
// Purpose : shared geometry helpers and stage record for the fiat_25519 pipelined multiplier.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   calc_slice_width - din1 bits consumed per pipeline stage (ceil(din1_WIDTH / NUM_STAGE)).
//   calc_full_width  - full-precision product width (din0_WIDTH + din1_WIDTH).
//   FULL_WIDTH / stage_t - stage record for the default 39x6 geometry. Parametrised
//   modules build a width-matched copy of the same record layout locally.
package fiat_25519_mul_pkg;

    localparam int DEF_DIN0_WIDTH = 39;
    localparam int DEF_DIN1_WIDTH = 6;
    localparam int FULL_WIDTH     = DEF_DIN0_WIDTH + DEF_DIN1_WIDTH;

    typedef struct packed {
        logic                      valid;
        logic [FULL_WIDTH-1:0]     acc;
        logic [DEF_DIN0_WIDTH-1:0] a;
        logic [DEF_DIN1_WIDTH-1:0] b_rem;
    } stage_t;

    function automatic int calc_slice_width(input int din1_width, input int num_stage);
        return (din1_width + num_stage - 1) / num_stage;
    endfunction

    function automatic int calc_full_width(input int din0_width, input int din1_width);
        return din0_width + din1_width;
    endfunction

endpackage

// File: rtl/fiat_25519_mul_pipe_stage.sv
// Purpose : one partial-product/accumulate register stage of the pipelined multiplier.
// Latency : 1 cycle (registered record).
// Backpressure: loads only when ld=1; otherwise holds its record unchanged.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (clears the record to zero)
//   ld            - load enable (clock enable AND advance from the ready chain)
//   in_vld/acc/a/b_rem   - record from the previous stage (or raw operands for stage 0)
//   out_vld/acc/a/b_rem  - registered record for the next stage
module fiat_25519_mul_pipe_stage
    import fiat_25519_mul_pkg::*;
#(
    parameter int STAGE_IDX  = 0,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 39,
    parameter int din1_WIDTH = 6,
    parameter int SIGNED     = 0,
    localparam int FW        = calc_full_width(din0_WIDTH, din1_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic                  in_vld,
    input  logic [FW-1:0]         in_acc,
    input  logic [din0_WIDTH-1:0] in_a,
    input  logic [din1_WIDTH-1:0] in_b_rem,
    output logic                  out_vld,
    output logic [FW-1:0]         out_acc,
    output logic [din0_WIDTH-1:0] out_a,
    output logic [din1_WIDTH-1:0] out_b_rem
);

    localparam int SW    = calc_slice_width(din1_WIDTH, NUM_STAGE);
    // Weight of this stage's slice inside the full product.
    localparam int SHIFT = STAGE_IDX * SW;

    typedef struct packed {
        logic                  valid;
        logic [FW-1:0]         acc;
        logic [din0_WIDTH-1:0] a;
        logic [din1_WIDTH-1:0] b_rem;
    } rec_t;

    rec_t          stage_q, stage_d;
    logic [FW-1:0] a_ext;
    logic [FW-1:0] slice_ext;
    logic [FW-1:0] pp;
    logic [FW-1:0] corr;

    always_comb begin
        if (SIGNED != 0) begin
            a_ext = {{din1_WIDTH{in_a[din0_WIDTH-1]}}, in_a};
        end else begin
            a_ext = {{din1_WIDTH{1'b0}}, in_a};
        end

        // Slices are always taken as unsigned; everything is computed mod 2^FW.
        slice_ext = FW'(in_b_rem[SW-1:0]);
        pp        = (a_ext * slice_ext) << SHIFT;

        // Signed din1 equals its unsigned reading minus sign*2^din1_WIDTH, so the
        // first stage pre-loads -(a << din1_WIDTH) when din1 is negative. Mod 2^FW
        // that shifted term is exactly {a, zeros}.
        corr = '0;
        if (STAGE_IDX == 0 && SIGNED != 0 && in_b_rem[din1_WIDTH-1]) begin
            corr = ~{in_a, {din1_WIDTH{1'b0}}} + FW'(1);
        end

        stage_d = stage_q;
        if (ld) begin
            stage_d.valid = in_vld;
            stage_d.acc   = in_acc + corr + pp;
            stage_d.a     = in_a;
            stage_d.b_rem = in_b_rem >> SW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_vld   = stage_q.valid;
    assign out_acc   = stage_q.acc;
    assign out_a     = stage_q.a;
    assign out_b_rem = stage_q.b_rem;

endmodule

// File: rtl/fiat_25519_carry_square_mul_pipe.sv
// Purpose : pipelined din0 x din1 multiplier (unsigned or signed) feeding the carry-reduction tree.
// Latency : NUM_STAGE cycles from accepted input to dout_valid; one result per cycle.
// Backpressure: bubble-collapsing ready chain; ce=0 freezes everything and drops din_ready.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   ce                    - clock enable for the whole pipeline
//   din_valid/din_ready   - operand handshake; din0, din1 operands
//   dout_valid/dout_ready - result handshake; dout product (truncated/extended to dout_WIDTH)
module fiat_25519_carry_square_mul_pipe
    import fiat_25519_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 39,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 44,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int FW = calc_full_width(din0_WIDTH, din1_WIDTH);

    logic [NUM_STAGE-1:0]  adv;
    logic [NUM_STAGE-1:0]  ld;
    logic                  accept;
    logic [NUM_STAGE-1:0]  st_vld;
    logic [FW-1:0]         st_acc [NUM_STAGE];
    logic [din0_WIDTH-1:0] st_a   [NUM_STAGE];
    logic [din1_WIDTH-1:0] st_b   [NUM_STAGE];
    logic [FW-1:0]         acc_last;

    // Ready chain: a stage may move if it is empty or the stage after it moves.
    always_comb begin
        adv = '0;
        adv[NUM_STAGE-1] = !st_vld[NUM_STAGE-1] | dout_ready;
        for (int k = NUM_STAGE - 2; k >= 0; k--) begin
            adv[k] = !st_vld[k] | adv[k+1];
        end
    end

    assign ld        = {NUM_STAGE{ce}} & adv;
    assign din_ready = ce & adv[0];
    assign accept    = din_valid & din_ready;

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        logic                  in_vld;
        logic [FW-1:0]         in_acc;
        logic [din0_WIDTH-1:0] in_a;
        logic [din1_WIDTH-1:0] in_b;

        if (k == 0) begin : g_head
            assign in_vld = accept;
            assign in_acc = '0;
            assign in_a   = din0;
            assign in_b   = din1;
        end else begin : g_body
            assign in_vld = st_vld[k-1];
            assign in_acc = st_acc[k-1];
            assign in_a   = st_a[k-1];
            assign in_b   = st_b[k-1];
        end

        fiat_25519_mul_pipe_stage #(
            .STAGE_IDX  (k),
            .NUM_STAGE  (NUM_STAGE),
            .din0_WIDTH (din0_WIDTH),
            .din1_WIDTH (din1_WIDTH),
            .SIGNED     (SIGNED)
        ) u_stage (
            .clk       (clk),
            .rst       (reset),
            .ld        (ld[k]),
            .in_vld    (in_vld),
            .in_acc    (in_acc),
            .in_a      (in_a),
            .in_b_rem  (in_b),
            .out_vld   (st_vld[k]),
            .out_acc   (st_acc[k]),
            .out_a     (st_a[k]),
            .out_b_rem (st_b[k])
        );
    end

    assign dout_valid = st_vld[NUM_STAGE-1];
    assign acc_last   = st_acc[NUM_STAGE-1];

    // The last stage's operand copies have no consumer; ID is a tag only.
    logic        unused_tail;
    logic [31:0] unused_id;
    assign unused_tail = ^{st_a[NUM_STAGE-1], st_b[NUM_STAGE-1]};
    assign unused_id   = ID;

    if (dout_WIDTH < FW) begin : g_trunc
        logic unused_hi;
        assign dout      = acc_last[dout_WIDTH-1:0];
        assign unused_hi = ^acc_last[FW-1:dout_WIDTH];
    end else if (dout_WIDTH == FW) begin : g_exact
        assign dout = acc_last;
    end else if (SIGNED != 0) begin : g_sext
        assign dout = {{(dout_WIDTH-FW){acc_last[FW-1]}}, acc_last};
    end else begin : g_zext
        assign dout = {{(dout_WIDTH-FW){1'b0}}, acc_last};
    end

endmodule
